// File: rtl/acia_tx_serializer.sv
// acia_tx_serializer: bit-level asynchronous transmitter for the 6551 ACIA emulation.
// A small byte FIFO feeds a start/data/parity/stop shifter; line format is latched
// from CTL/CMD at the start of every frame.
//
// Ports:
//   CLK      system clock
//   RESET_N  asynchronous active-low reset
//   XTAL_CE  1.8432 MHz clock enable, single-CLK pulse; bit timing counts these
//   CTL      control reg: [3:0] baud code, [6:5] word length, [7] stop-bit select
//   CMD      command reg: [0] TX enable, [3:2] TX control, [5] parity en, [7:6] parity mode
//   DATA_IN  byte to transmit, qualified by WR_STB
//   WR_STB   one-CLK write strobe
//   CTS_N    clear-to-send, active low
//   TXD      serial output, idle high
//   TDRE     FIFO not full (registered)
//   TX_BUSY  frame in progress or FIFO non-empty
//   OVERFLOW one-CLK pulse when a write to a full FIFO is dropped
module acia_tx_serializer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       XTAL_CE,
    input  logic [7:0] CTL,
    input  logic [7:0] CMD,
    input  logic [7:0] DATA_IN,
    input  logic       WR_STB,
    input  logic       CTS_N,
    output logic       TXD,
    output logic       TDRE,
    output logic       TX_BUSY,
    output logic       OVERFLOW
);

    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreak
    } state_t;

    // Bit time in XTAL_CE ticks for each baud code.
    function automatic logic [15:0] baud_ticks(input logic [3:0] code);
        logic [15:0] n;
        case (code)
            4'h0:    n = 16'd16;
            4'h1:    n = 16'd36864;
            4'h2:    n = 16'd24576;
            4'h3:    n = 16'd16769;
            4'h4:    n = 16'd13696;
            4'h5:    n = 16'd12288;
            4'h6:    n = 16'd6144;
            4'h7:    n = 16'd3072;
            4'h8:    n = 16'd1536;
            4'h9:    n = 16'd1024;
            4'hA:    n = 16'd768;
            4'hB:    n = 16'd512;
            4'hC:    n = 16'd384;
            4'hD:    n = 16'd256;
            4'hE:    n = 16'd192;
            default: n = 16'd96;
        endcase
        return n;
    endfunction

    // FIFO
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_d;
    logic          r_tdre;
    logic          r_ovf;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_start_ok;
    logic [7:0]    w_head;

    // Frame engine
    state_t        r_state;
    logic          r_txd;
    logic [15:0]   r_tick;
    logic [15:0]   r_n;
    logic [7:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic          r_par_en;
    logic          r_par_bit;
    logic          r_stop_two;
    logic          r_stop_half;
    logic          r_stop_second;
    logic          r_brk_rel;
    logic [15:0]   w_limit;
    logic          w_tick_done;
    logic          w_counting;
    logic [7:0]    w_mask;
    logic          w_par_bit;
    logic          w_stop_two;
    logic          w_stop_half;
    logic          w_unused;

    assign w_unused = ^{CTL[4], CMD[4], CMD[1]};

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rptr];
    assign w_start_ok = !w_empty && CMD[0] && !CTS_N && (CMD[3:2] != 2'b11);
    assign w_pop      = (r_state == StIdle) && w_start_ok;
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign w_push     = WR_STB && (!w_full || w_pop);
    assign w_count_d  = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_mask = 8'hFF >> CTL[6:5];
        case (CMD[7:6])
            2'b00:   w_par_bit = ~^(w_head & w_mask);
            2'b01:   w_par_bit = ^(w_head & w_mask);
            2'b10:   w_par_bit = 1'b1;
            default: w_par_bit = 1'b0;
        endcase
        w_stop_two  = 1'b0;
        w_stop_half = 1'b0;
        if (CTL[7]) begin
            if (CTL[6:5] == 2'b11 && !CMD[5]) begin
                // 5 bits, no parity: 1.5 stop bits
                w_stop_two  = 1'b1;
                w_stop_half = 1'b1;
            end else if (!(CTL[6:5] == 2'b00 && CMD[5])) begin
                w_stop_two = 1'b1;
            end
        end
        // Second half of a 1.5-stop segment runs for half a bit time.
        w_limit = (r_state == StStop && r_stop_second && r_stop_half) ? (r_n >> 1) : r_n;
    end

    assign w_tick_done = XTAL_CE && (r_tick == w_limit - 16'd1);
    assign w_counting  = (r_state != StIdle) && !(r_state == StBreak && !r_brk_rel);

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= DATA_IN;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_tdre  <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_d;
            r_tdre  <= (w_count_d != FULL_CNT);
            r_ovf   <= WR_STB && !w_push;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= StIdle;
            r_txd         <= 1'b1;
            r_tick        <= '0;
            r_n           <= '0;
            r_shift       <= '0;
            r_bitcnt      <= '0;
            r_par_en      <= 1'b0;
            r_par_bit     <= 1'b0;
            r_stop_two    <= 1'b0;
            r_stop_half   <= 1'b0;
            r_stop_second <= 1'b0;
            r_brk_rel     <= 1'b0;
        end else begin
            if (w_counting && XTAL_CE) r_tick <= w_tick_done ? '0 : r_tick + 16'd1;
            case (r_state)
                StIdle: begin
                    r_txd <= 1'b1;
                    if (CMD[3:2] == 2'b11) begin
                        r_state   <= StBreak;
                        r_txd     <= 1'b0;
                        r_brk_rel <= 1'b0;
                    end else if (w_pop) begin
                        // Latch the whole line format so register writes cannot disturb it.
                        r_state       <= StStart;
                        r_txd         <= 1'b0;
                        r_tick        <= '0;
                        r_n           <= baud_ticks(CTL[3:0]);
                        r_shift       <= w_head;
                        r_bitcnt      <= 4'd7 - {2'b00, CTL[6:5]};
                        r_par_en      <= CMD[5];
                        r_par_bit     <= w_par_bit;
                        r_stop_two    <= w_stop_two;
                        r_stop_half   <= w_stop_half;
                        r_stop_second <= 1'b0;
                    end
                end
                StStart: begin
                    if (w_tick_done) begin
                        r_state <= StData;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                StData: begin
                    if (w_tick_done) begin
                        if (r_bitcnt != 4'd0) begin
                            r_txd    <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitcnt <= r_bitcnt - 4'd1;
                        end else if (r_par_en) begin
                            r_state <= StParity;
                            r_txd   <= r_par_bit;
                        end else begin
                            r_state <= StStop;
                            r_txd   <= 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (w_tick_done) begin
                        r_state <= StStop;
                        r_txd   <= 1'b1;
                    end
                end
                StStop: begin
                    if (w_tick_done) begin
                        if (r_stop_two && !r_stop_second) r_stop_second <= 1'b1;
                        else                              r_state       <= StIdle;
                    end
                end
                StBreak: begin
                    if (!r_brk_rel) begin
                        r_txd <= 1'b0;
                        if (CMD[3:2] != 2'b11) begin
                            // Guarantee one full mark bit after the break.
                            r_brk_rel <= 1'b1;
                            r_txd     <= 1'b1;
                            r_tick    <= '0;
                            r_n       <= baud_ticks(CTL[3:0]);
                        end
                    end else if (w_tick_done) begin
                        r_state   <= StIdle;
                        r_brk_rel <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign TXD      = r_txd;
    assign TDRE     = r_tdre;
    assign OVERFLOW = r_ovf;
    assign TX_BUSY  = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_acia_tx_serializer.sv
// tb_acia_tx_serializer: directed + randomized bench for acia_tx_serializer.
// The reference model expands each byte into the expected TXD level per XTAL_CE tick
// (start, data, parity, stop) straight from the line-format rules and compares TXD
// against it while XTAL_CE pulses at random.
module tb_acia_tx_serializer;

    localparam int unsigned DEPTH = 4;

    logic       CLK;
    logic       RESET_N;
    logic       XTAL_CE;
    logic [7:0] CTL;
    logic [7:0] CMD;
    logic [7:0] DATA_IN;
    logic       WR_STB;
    logic       CTS_N;
    logic       TXD;
    logic       TDRE;
    logic       TX_BUSY;
    logic       OVERFLOW;

    int         n_cmp  = 0;
    int         n_fail = 0;
    bit         exp_wave [$];
    logic [7:0] mq [$];
    int         baud_tbl [16] = '{16, 36864, 24576, 16769, 13696, 12288, 6144, 3072,
                                  1536, 1024, 768, 512, 384, 256, 192, 96};

    acia_tx_serializer #(.DEPTH(4), .AW(2)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .XTAL_CE  (XTAL_CE),
        .CTL      (CTL),
        .CMD      (CMD),
        .DATA_IN  (DATA_IN),
        .WR_STB   (WR_STB),
        .CTS_N    (CTS_N),
        .TXD      (TXD),
        .TDRE     (TDRE),
        .TX_BUSY  (TX_BUSY),
        .OVERFLOW (OVERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // XTAL_CE changes on the falling edge, so it is stable around the rising edge.
    initial begin
        XTAL_CE = 1'b0;
        forever begin
            @(negedge CLK);
            XTAL_CE = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected TXD level for every XTAL_CE tick of one frame.
    function automatic void build_wave(input logic [7:0] ctl, input logic [7:0] cmd,
                                       input logic [7:0] data);
        int n;
        int nb;
        int ones;
        int stop_ticks;
        bit pbit;
        n    = baud_tbl[ctl[3:0]];
        nb   = 8 - int'(ctl[6:5]);
        ones = 0;
        pbit = 1'b0;
        exp_wave.delete();
        repeat (n) exp_wave.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            repeat (n) exp_wave.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (cmd[5]) begin
            case (cmd[7:6])
                2'b00:   pbit = (ones % 2 == 0);
                2'b01:   pbit = (ones % 2 == 1);
                2'b10:   pbit = 1'b1;
                default: pbit = 1'b0;
            endcase
            repeat (n) exp_wave.push_back(pbit);
        end
        if (!ctl[7])                 stop_ticks = n;
        else if (nb == 5 && !cmd[5]) stop_ticks = (3 * n) / 2;
        else if (nb == 8 && cmd[5])  stop_ticks = n;
        else                         stop_ticks = 2 * n;
        repeat (stop_ticks) exp_wave.push_back(1'b1);
    endfunction

    task automatic write_byte(input logic [7:0] d);
        DATA_IN = d;
        WR_STB  = 1'b1;
        step();
        WR_STB  = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(d);
    endtask

    // Steps until TXD goes low; exp_cycles is the required number of clock edges.
    task automatic wait_start(input string tag, input int exp_cycles);
        int c;
        c = 0;
        while (TXD !== 1'b0 && c < 1000) begin
            step();
            c++;
        end
        chk(tag, c, exp_cycles);
    endtask

    // Called right after the edge that drove the start bit. Optionally changes CTL/CMD
    // (and writes a byte) once act_at ticks of the frame have elapsed.
    task automatic run_frame(input string tag, input int act_at, input logic [7:0] act_ctl,
                             input logic [7:0] act_cmd, input bit act_wr,
                             input logic [7:0] act_data);
        int k;
        int guard;
        int len;
        bit acted;
        logic [7:0] d;
        d = mq.pop_front();
        build_wave(CTL, CMD, d);
        len   = exp_wave.size();
        k     = 0;
        guard = 0;
        acted = 1'b0;
        while (k < len && guard < 8 * len + 100) begin
            chk({tag, "_txd"}, TXD, exp_wave[k]);
            chk({tag, "_busy"}, TX_BUSY, 1);
            if (!acted && k >= act_at) begin
                acted = 1'b1;
                CTL   = act_ctl;
                CMD   = act_cmd;
                if (act_wr) begin
                    DATA_IN = act_data;
                    WR_STB  = 1'b1;
                    if (mq.size() < DEPTH) mq.push_back(act_data);
                end
            end
            step();
            WR_STB = 1'b0;
            guard++;
            if (XTAL_CE) k++;
        end
        chk({tag, "_len"}, k, len);
        chk({tag, "_stop_txd"}, TXD, 1);
    endtask

    logic [7:0] r_c;
    logic [7:0] r_m;
    logic [7:0] r_d;
    logic       exp_ovf;
    int         kk;

    initial begin
        RESET_N = 1'b0;
        WR_STB  = 1'b0;
        DATA_IN = 8'h00;
        CTL     = 8'h1E;
        CMD     = 8'h01;
        CTS_N   = 1'b0;
        repeat (3) step();
        chk("rst_txd", TXD, 1);
        chk("rst_tdre", TDRE, 1);
        chk("rst_busy", TX_BUSY, 0);
        chk("rst_ovf", OVERFLOW, 0);
        RESET_N = 1'b1;
        step();
        step();

        // 8N1, 192 ticks/bit
        write_byte(8'h55);
        chk("8n1_pre_txd", TXD, 1);
        chk("8n1_pre_busy", TX_BUSY, 1);
        wait_start("8n1_latency", 1);
        run_frame("8n1", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        chk("8n1_busy_end", TX_BUSY, 0);

        // 7E1, 96 ticks/bit; bit 7 dropped
        CTL = 8'h3F;
        CMD = 8'h61;
        write_byte(8'h41);
        wait_start("7e1_latency", 1);
        run_frame("7e1", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        chk("7e1_busy_end", TX_BUSY, 0);

        // 5 bits, 2-stop select without parity -> 1.5 stop bits
        CTL = 8'hFF;
        CMD = 8'h01;
        write_byte(8'h1F);
        wait_start("5n15_latency", 1);
        run_frame("5n15", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        // same with mark parity -> 2 stop bits
        CMD = 8'hA1;
        write_byte(8'h1F);
        wait_start("5m2_latency", 1);
        run_frame("5m2", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        chk("5m2_busy_end", TX_BUSY, 0);

        // Random formats; CTL/CMD scrambled mid-frame must not affect the frame
        for (int i = 0; i < 6; i++) begin
            r_c      = 8'($urandom);
            r_c[3:0] = r_c[4] ? 4'hF : 4'h0;
            r_m      = 8'($urandom);
            r_m[0]   = 1'b1;
            r_m[3:2] = 2'b00;
            r_d      = 8'($urandom);
            CTL = r_c;
            CMD = r_m;
            write_byte(r_d);
            wait_start("rnd_latency", 1);
            run_frame("rnd", baud_tbl[r_c[3:0]] * 2, 8'($urandom),
                      8'($urandom) & 8'hF7, 1'b0, 8'h00);
            chk("rnd_busy_end", TX_BUSY, 0);
        end

        // FIFO full with CTS_N high
        CTL   = 8'h10;
        CMD   = 8'h01;
        CTS_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DATA_IN = 8'hA0 + 8'(i * 17);
            WR_STB  = 1'b1;
            step();
            exp_ovf = (mq.size() >= DEPTH);
            if (!exp_ovf) mq.push_back(DATA_IN);
            chk("fifo_tdre", TDRE, mq.size() < DEPTH);
            chk("fifo_ovf", OVERFLOW, exp_ovf);
        end
        WR_STB = 1'b0;
        step();
        chk("fifo_ovf_clear", OVERFLOW, 0);
        chk("fifo_held_txd", TXD, 1);
        chk("fifo_held_busy", TX_BUSY, 1);
        CTS_N = 1'b0;
        wait_start("fifo_f1_start", 1);
        run_frame("fifo_f1", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        chk("fifo_tdre_free", TDRE, 1);
        wait_start("fifo_f2_b2b", 1);
        run_frame("fifo_f2", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        wait_start("fifo_f3_b2b", 1);
        // transmitter disabled mid-frame: frame completes, next one is held
        run_frame("fifo_f3", 40, CTL, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("fifo_disabled_txd", TXD, 1);
        end
        chk("fifo_disabled_busy", TX_BUSY, 1);
        CMD = 8'h01;
        wait_start("fifo_f4_start", 1);
        run_frame("fifo_f4", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        chk("fifo_busy_end", TX_BUSY, 0);

        // Break requested mid-frame with a byte queued behind it
        CTL = 8'h1F;
        CMD = 8'h01;
        write_byte(8'hC3);
        wait_start("brk_f1_start", 1);
        run_frame("brk_f1", 3 * 96, CTL, 8'h0D, 1'b1, 8'h3C);
        wait_start("brk_entry", 1);
        for (int i = 0; i < 60; i++) begin
            step();
            chk("brk_hold_txd", TXD, 0);
            chk("brk_hold_busy", TX_BUSY, 1);
        end
        CMD = 8'h01;
        step();
        chk("brk_rel_txd", TXD, 1);
        kk = 0;
        for (int g = 0; g < 2000 && kk < 96; g++) begin
            step();
            if (XTAL_CE) kk++;
            chk("brk_rel_mark", TXD, 1);
        end
        chk("brk_rel_len", kk, 96);
        wait_start("brk_next_start", 1);
        run_frame("brk_next", 1 << 30, CTL, CMD, 1'b0, 8'h00);
        chk("brk_busy_end", TX_BUSY, 0);

        // Reset during DATA with another byte queued
        CTL = 8'h10;
        CMD = 8'h01;
        write_byte(8'h96);
        wait_start("rstmid_start", 1);
        write_byte(8'h69);
        kk = 0;
        for (int g = 0; g < 2000 && kk < 22; g++) begin
            step();
            if (XTAL_CE) kk++;
        end
        chk("rstmid_data_bit", TXD, 0);
        RESET_N = 1'b0;
        #1;
        mq.delete();
        chk("rstmid_txd", TXD, 1);
        chk("rstmid_tdre", TDRE, 1);
        chk("rstmid_busy", TX_BUSY, 0);
        chk("rstmid_ovf", OVERFLOW, 0);
        step();
        RESET_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("rstmid_idle_txd", TXD, 1);
            chk("rstmid_idle_busy", TX_BUSY, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/acia_tx_serializer.md
Name: acia_tx_serializer

Overview:
Bit-level asynchronous transmitter for the 6551 ACIA emulation. It takes bytes from the CPU TX data-register write path and drives the physical TXD line with correctly timed start, data, parity and stop bits. Line format comes from the ACIA control and command registers. A small byte FIFO sits in front of the shifter and provides TDRE back to the ACIA status register.

Parameters:
DEPTH, 4, TX byte FIFO entries (power of two, ≥2)
AW, 2, FIFO address width = log2(DEPTH)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
XTAL_CE  in  1  1.8432 MHz clock enable, single-CLK pulse
CTL  in  8  ACIA control reg: [3:0] baud code, [6:5] word length, [7] stop-bit select
CMD  in  8  ACIA command reg: [0] transmitter enable, [3:2] TX control, [5] parity enable, [7:6] parity mode
DATA_IN  in  8  byte to transmit
WR_STB  in  1  one-CLK write strobe for DATA_IN
CTS_N  in  1  clear-to-send, active low
TXD  out  1  serial output, idle high
TDRE  out  1  FIFO not full
TX_BUSY  out  1  frame in progress or FIFO non-empty
OVERFLOW  out  1  one-CLK pulse when a write to a full FIFO is dropped

Behaviour:
- Reset (async, RESET_N low):
  - TXD=1, TDRE=1, TX_BUSY=0, OVERFLOW=0.
  - FIFO empty, state IDLE, all counters 0.
  - Reset mid-frame aborts the frame immediately; TXD returns to 1.
- Bit time N in XTAL_CE ticks, selected by CTL[3:0]:
  - 0→16, 1→36864, 2→24576, 3→16769, 4→13696, 5→12288, 6→6144, 7→3072
  - 8→1536, 9→1024, A→768, B→512, C→384, D→256, E→192, F→96
  - Tick counter is 16 bits; bit boundary is when the count reaches N-1, then the counter returns to 0.
- Word length CTL[6:5]: 00=8, 01=7, 10=6, 11=5 data bits, LSB first.
- Stop bits:
  - CTL[7]=0 → 1 stop bit.
  - CTL[7]=1 → 2 stop bits, with two exceptions:
    - 5 bits without parity → 1.5 stop bits (3N/2 ticks).
    - 8 bits with parity → 1 stop bit.
- Parity:
  - Enabled when CMD[5]=1.
  - CMD[7:6]: 00 odd, 01 even, 10 mark (1), 11 space (0).
  - Odd/even parity is computed over the active data bits only.
- FIFO:
  - WR_STB with FIFO not full → push.
  - WR_STB with FIFO full → drop, and pulse OVERFLOW on the next CLK.
  - Push and pop in the same cycle when full → write accepted (pop frees the slot first).
  - TDRE = !full, registered.
  - TX_BUSY = (state!=IDLE) || !empty.
- State machine:
  - States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: TXD=1.
    - Start a frame when the FIFO is non-empty, CMD[0]=1, CTS_N=0 and CMD[3:2]!=11.
    - On start: pop the FIFO into the shift register, latch CTL/CMD for the whole frame, clear the tick counter, go to START.
    - TXD goes low on the CLK after the pop.
    - Latency: WR_STB into an empty FIFO in IDLE → TXD=0 exactly 2 CLKs later.
  - START: TXD=0 for N ticks → DATA.
  - DATA: shift out the word-length count of bits, N ticks each → PARITY if enabled, else STOP.
  - PARITY: parity bit for N ticks → STOP.
  - STOP: TXD=1 for 1, 1.5 or 2 bit times.
    - Then go to IDLE.
    - A next frame may start in the following cycle (back-to-back frames, no extra idle).
  - BREAK:
    - Entered from IDLE when CMD[3:2]==11, with no FIFO pop.
    - TXD=0 while CMD[3:2]==11.
    - Leaving BREAK: TXD=1 for one full bit time, then IDLE.
- Boundary conditions:
  - CTL/CMD changes mid-frame do not affect the current frame.
  - CTS_N rising or CMD[0] clearing mid-frame → the current frame completes; no new frame starts until the condition clears.
  - Break requested mid-frame → takes effect after STOP completes.
  - XTAL_CE and WR_STB are independent and may coincide.
  - Tick counter advances only on XTAL_CE.

Test Plan:
- 8N1: CTL=0x1E, CMD=0x01, write 0x55.
  - TXD goes low 2 CLKs after WR_STB.
  - Then 0,1,0,1,0,1,0,1,0 each 192 ticks, then 1 for 192 ticks.
  - TX_BUSY drops when the stop bit ends.
- 7E1: CTL=0x3F, CMD=0x61, write 0x41.
  - Bits at 96 ticks each: start 0; data 1,0,0,0,0,0,1; parity 0; stop 1.
  - Bit 7 of the byte is not sent.
- 5-bit, 2-stop, no parity: CTL=0xFF, write 0x1F.
  - Stop segment is 144 ticks (1.5 bits).
  - Repeat with CMD[5]=1, mark parity: parity bit 1, stop segment 192 ticks.
- FIFO full: 5 back-to-back WR_STB with CTS_N=1.
  - TDRE=0 after the 4th write.
  - OVERFLOW pulses once; the 5th byte is lost.
  - After CTS_N→0, 4 frames go out back-to-back, byte order preserved.
- Break: set CMD[3:2]=11 during a frame.
  - The frame completes, then TXD=0 held.
  - Clearing the break gives one bit time of TXD=1, then the queued byte transmits.
- Reset mid-frame: assert RESET_N low during DATA.
  - TXD=1 and TDRE=1 immediately.
  - FIFO empty; no frame after release.
